// File: rtl/demux_sel_sequencer.sv
// Scan sequencer for a downstream demux_1x16: visits each enabled channel in
// ascending order, holding its select for dwell+1 cycles while driving the latched level.
module demux_sel_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               level,
  output logic               in,
  output logic [3:0]         sel,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};

  state_t             state_r;
  logic [15:0]        work_mask_r;
  logic [DWELL_W-1:0] dwell_q_r;
  logic [DWELL_W-1:0] cnt_r;
  logic               level_q_r;
  logic [3:0]         sel_q_r;
  logic [15:0]        mask_after_s;

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Pending set with the currently dwelling channel retired
  assign mask_after_s = work_mask_r & ~(16'h0001 << sel_q_r);

  // Scan FSM; the output bank is a registered image of the previous cycle's state,
  // except that an abort blanks in/busy on the very next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      work_mask_r <= 16'h0000;
      dwell_q_r   <= CNT_ZERO;
      cnt_r       <= CNT_ZERO;
      level_q_r   <= 1'b0;
      sel_q_r     <= 4'd0;
      in          <= 1'b0;
      sel         <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      in   <= (state_r == DWELL) ? level_q_r : 1'b0;
      sel  <= sel_q_r;
      busy <= (state_r == SEEK) || (state_r == DWELL);
      done <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            work_mask_r <= mask;
            dwell_q_r   <= dwell;
            level_q_r   <= level;
            state_r     <= (mask != 16'h0000) ? SEEK : DONE;
          end else begin
            state_r <= IDLE;
          end
        end
        SEEK: begin
          if (abort) begin
            state_r     <= IDLE;
            work_mask_r <= 16'h0000;
            in          <= 1'b0;
            busy        <= 1'b0;
          end else if (work_mask_r != 16'h0000) begin
            sel_q_r <= lowest_set(work_mask_r);
            cnt_r   <= dwell_q_r;
            state_r <= DWELL;
          end else begin
            state_r <= DONE;
          end
        end
        DWELL: begin
          if (abort) begin
            state_r     <= IDLE;
            work_mask_r <= 16'h0000;
            in          <= 1'b0;
            busy        <= 1'b0;
          end else if (cnt_r == CNT_ZERO) begin
            // Last channel retired: skip the empty SEEK so done follows the final dwell
            work_mask_r <= mask_after_s;
            state_r     <= (mask_after_s != 16'h0000) ? SEEK : DONE;
          end else begin
            cnt_r <= cnt_r - DWELL_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Scoreboard bench for demux_sel_sequencer: a timing-formula reference model queues
// per-cycle expectations, a monitor pops and compares them every cycle.
module tb_demux_sel_sequencer;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [15:0]        mask = 16'h0000;
  logic [DWELL_W-1:0] dwell = '0;
  logic               level = 1'b0;
  logic               dout;
  logic [3:0]         sel;
  logic               busy;
  logic               done;

  typedef struct {
    int         t;
    logic       e_in;
    logic [3:0] e_sel;
    logic       e_done;
    logic       b_care;
    logic       e_busy;
  } exp_t;

  exp_t       sb[$];
  int         nvec = 0;
  int         nerr = 0;
  string      scen = "reset";
  logic [3:0] last_sel = 4'd0;

  demux_sel_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .mask  (mask),
    .dwell (dwell),
    .level (level),
    .in    (dout),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: channel k shows on sel from cycle k*(d+2)+2, in=level for d+1 cycles,
  // done at cycle N*(d+2)+1; an abort at cycle A blanks everything from A on.
  function automatic void push_scan(input logic [15:0] m, input int d, input logic lv,
                                    input int abort_at, input int limit);
    int         chs[$];
    int         n, p, k, r;
    exp_t       e;
    logic [3:0] held;
    for (int i = 0; i < 16; i++) if (m[i]) chs.push_back(i);
    n = chs.size();
    p = d + 2;
    held = last_sel;
    for (int t = 0; t <= limit; t++) begin
      e.t = t; e.e_in = 1'b0; e.e_sel = last_sel; e.e_done = 1'b0;
      e.b_care = 1'b1; e.e_busy = 1'b0;
      if (abort_at >= 0 && t >= abort_at) begin
        e.e_sel = held;
      end else begin
        if (n > 0 && t >= 2) begin
          k = (t - 2) / p;
          r = (t - 2) % p;
          if (k < n) begin
            e.e_sel = 4'(chs[k]);
            e.e_in  = (r <= d) ? lv : 1'b0;
          end else begin
            e.e_sel = 4'(chs[n-1]);
          end
        end
        e.e_done = (t == n * p + 1);
        if (n > 0) begin
          if (t == 1) e.b_care = 1'b0;
          else        e.e_busy = (t >= 2 && t <= n * p);
        end
        held = e.e_sel;
      end
      sb.push_back(e);
    end
    last_sel = held;
  endfunction

  function automatic void push_zero(input int t);
    exp_t e;
    e.t = t; e.e_in = 1'b0; e.e_sel = 4'd0; e.e_done = 1'b0;
    e.b_care = 1'b1; e.e_busy = 1'b0;
    sb.push_back(e);
  endfunction

  // Monitor: every output cycle (and on reset assertion) compare against the queue head
  always @(negedge clk or negedge rst_n) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      nvec++;
      if (dout !== e.e_in || sel !== e.e_sel || done !== e.e_done ||
          (e.b_care && busy !== e.e_busy)) begin
        nerr++;
        $display("FAIL %s t=%0d: got in=%b sel=%0d busy=%b done=%b, expected in=%b sel=%0d busy=%b(care=%b) done=%b",
                 scen, e.t, dout, sel, busy, done, e.e_in, e.e_sel, e.e_busy, e.b_care, e.e_done);
      end
    end
  end

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain %s: %0d entries left, expected 0", scen, sb.size());
      $fatal(1, "scoreboard stalled");
    end
  endtask

  task automatic run_scan(input string nm, input logic [15:0] m, input int d, input logic lv,
                          input int abort_at, input int rst_at);
    int n, last;
    n = $countones(m);
    scen = nm;
    mask = m; dwell = DWELL_W'(d); level = lv; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (rst_at >= 0)        last = rst_at;
    else if (abort_at >= 0) last = abort_at + 3;
    else                    last = n * (d + 2) + 2;
    push_scan(m, d, lv, abort_at, last);
    for (int c = 1; c <= last; c++) begin
      mask  = 16'($urandom);
      dwell = DWELL_W'($urandom);
      level = 1'($urandom);
      start = ((abort_at < 0 || c < abort_at) && c <= n * (d + 2)) ? 1'($urandom) : 1'b0;
      abort = (c == abort_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (rst_at >= 0) begin
      #7;
      for (int i = 0; i < 4; i++) push_zero(-1 - i);
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      last_sel = 4'd0;
    end
    wait_drain();
  endtask

  task automatic abort_beats_start();
    exp_t e;
    scen = "abort_beats_start";
    mask = 16'hFFFF; dwell = DWELL_W'(1); level = 1'b1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int t = 0; t <= 3; t++) begin
      e.t = t; e.e_in = 1'b0; e.e_sel = last_sel; e.e_done = 1'b0;
      e.b_care = 1'b1; e.e_busy = 1'b0;
      sb.push_back(e);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    wait_drain();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] rm;
    #1 rst_n = 1'b0;
    #2 push_zero(-100);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain();

    run_scan("full_sweep", 16'hFFFF, 0, 1'b1, -1, -1);
    run_scan("sparse",     16'h8421, 2, 1'b1, -1, -1);
    run_scan("empty",      16'h0000, 5, 1'b1, -1, -1);
    run_scan("level0",     16'h0003, 1, 1'b0, -1, -1);
    run_scan("abort_ch2",  16'hFFFF, 3, 1'b1, 13, -1);
    run_scan("restart",    16'hFFFF, 3, 1'b1, -1, -1);
    run_scan("reset_ch4",  16'hFFFF, 2, 1'b1, -1, 19);
    run_scan("post_reset", 16'h0110, 1, 1'b1, -1, -1);
    abort_beats_start();
    run_scan("after_abort_start", 16'h4002, 0, 1'b1, -1, -1);

    for (int i = 0; i < 16; i++) begin
      case ($urandom % 4)
        0:       rm = 16'($urandom);
        1:       rm = 16'($urandom & $urandom & $urandom);
        2:       rm = 16'h0001 << $urandom_range(0, 15);
        default: rm = ($urandom % 3 == 0) ? 16'h0000 : 16'hFFFF;
      endcase
      run_scan("random", rm, int'($urandom_range(0, 15)), 1'($urandom), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
